arm_hazard_scoreboard: RTL and testbench

//  Parametrised hazard, forwarding and stall controller for the ARM pipeline; successor to the stall-only hazard detector.

---
 rtl/arm_hazard_scoreboard.sv | 127 ++++++++++++
 tb/tb_arm_hazard_scoreboard.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_hazard_scoreboard.sv
// Hazard, forwarding and stall controller for the ARM pipeline.
// Tracks in-flight register writers per post-ID stage and drives stall/forward/freeze.
module arm_hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fwd_enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_has_src1,
    input  logic                  id_has_src2,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  mem_ready,
    output logic                  hazard_stall,
    output logic                  mem_freeze,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  wb_en;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic                  has_src1;
        logic                  has_src2;
    } slot_t;

    slot_t slots [PIPE_DEPTH];
    slot_t id_slot;
    logic  any_match;
    logic  load_use;
    logic  advance_id;
    logic  unused_fields;

    function automatic logic writes(input slot_t s, input logic has,
                                    input logic [REG_ADDR_W-1:0] src);
        return has & s.valid & s.wb_en & (src == s.dst);
    endfunction

    // MEM forwards only ALU results; a load in MEM is never a forward source.
    function automatic logic [1:0] pick(input slot_t mem_s, input slot_t wb_s,
                                        input logic has,
                                        input logic [REG_ADDR_W-1:0] src);
        if (writes(mem_s, has, src) & ~mem_s.is_load)
            return 2'd1;
        else if (writes(wb_s, has, src))
            return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        id_slot          = '0;
        id_slot.valid    = 1'b1;
        id_slot.dst      = id_dst;
        id_slot.wb_en    = id_wb_en;
        id_slot.is_load  = id_mem_read;
        id_slot.src1     = id_src1;
        id_slot.src2     = id_src2;
        id_slot.has_src1 = id_has_src1;
        id_slot.has_src2 = id_has_src2;
    end

    // The last slot writes back this cycle and the register file bypasses it.
    always_comb begin
        any_match = 1'b0;
        for (int k = 0; k < PIPE_DEPTH - 1; k++) begin
            any_match = any_match
                      | writes(slots[k], id_has_src1, id_src1)
                      | writes(slots[k], id_has_src2, id_src2);
        end
    end

    always_comb begin
        load_use = slots[0].is_load
                 & (writes(slots[0], id_has_src1, id_src1)
                  | writes(slots[0], id_has_src2, id_src2));
        hazard_stall = id_valid & ~flush & (fwd_enable ? load_use : any_match);
        mem_freeze   = slots[1].valid & slots[1].is_load & ~mem_ready;
        advance_id   = id_valid & ~hazard_stall & ~flush;
    end

    always_comb begin
        fwd_sel_a = 2'd0;
        fwd_sel_b = 2'd0;
        if (fwd_enable & slots[0].valid) begin
            fwd_sel_a = pick(slots[1], slots[2], slots[0].has_src1, slots[0].src1);
            fwd_sel_b = pick(slots[1], slots[2], slots[0].has_src2, slots[0].src2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++)
                slots[k] <= '0;
        end else if (!mem_freeze) begin
            slots[0] <= advance_id ? id_slot : '0;
            for (int k = 1; k < PIPE_DEPTH; k++)
                slots[k] <= slots[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count <= '0;
        else if ((hazard_stall | mem_freeze) && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

    // Older slots keep their sources only so the scoreboard layout is uniform.
    always_comb begin
        unused_fields = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++)
            unused_fields = unused_fields ^ (^slots[k]);
    end

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Directed bench for arm_hazard_scoreboard: stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_arm_hazard_scoreboard;

    localparam int SIG_STALL  = 0;
    localparam int SIG_FREEZE = 1;
    localparam int SIG_FA     = 2;
    localparam int SIG_FB     = 3;
    localparam int SIG_CNT    = 4;
    localparam int SIG_SMALL  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       fwd_enable;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_has_src1;
    logic       id_has_src2;
    logic [3:0] id_dst;
    logic       id_wb_en;
    logic       id_mem_read;
    logic       flush;
    logic       mem_ready;

    logic        hazard_stall;
    logic        mem_freeze;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [15:0] stall_count;

    logic        s_stall;
    logic        s_freeze;
    logic [1:0]  s_fa;
    logic [1:0]  s_fb;
    logic [3:0]  s_count;

    arm_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .fwd_enable(fwd_enable), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_has_src1(id_has_src1), .id_has_src2(id_has_src2),
        .id_dst(id_dst), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .flush(flush), .mem_ready(mem_ready),
        .hazard_stall(hazard_stall), .mem_freeze(mem_freeze),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_count(stall_count)
    );

    arm_hazard_scoreboard #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .fwd_enable(fwd_enable), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_has_src1(id_has_src1), .id_has_src2(id_has_src2),
        .id_dst(id_dst), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .flush(flush), .mem_ready(mem_ready),
        .hazard_stall(s_stall), .mem_freeze(s_freeze),
        .fwd_sel_a(s_fa), .fwd_sel_b(s_fb),
        .stall_count(s_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   act;
    int   checks = 0;
    int   errors = 0;

    function automatic int actual(input int sig);
        case (sig)
            SIG_STALL:  return int'(hazard_stall);
            SIG_FREEZE: return int'(mem_freeze);
            SIG_FA:     return int'(fwd_sel_a);
            SIG_FB:     return int'(fwd_sel_b);
            SIG_CNT:    return int'(stall_count);
            default:    return int'(s_count);
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            act = actual(e.sig);
            checks++;
            if (act != e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                         e.name, act, e.val, e.cyc);
            end
        end
    end

    task automatic chk(input int sig, input int val, input string name);
        exp_t x;
        x.cyc  = cyc;
        x.sig  = sig;
        x.val  = val;
        x.name = name;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_src1     = '0;
        id_src2     = '0;
        id_has_src1 = 1'b0;
        id_has_src2 = 1'b0;
        id_dst      = '0;
        id_wb_en    = 1'b0;
        id_mem_read = 1'b0;
    endtask

    task automatic issue(input logic [3:0] d, input logic [3:0] s1,
                         input logic [3:0] s2, input logic h1, input logic h2,
                         input logic ld);
        id_valid    = 1'b1;
        id_dst      = d;
        id_src1     = s1;
        id_src2     = s2;
        id_has_src1 = h1;
        id_has_src2 = h2;
        id_wb_en    = 1'b1;
        id_mem_read = ld;
    endtask

    task automatic do_reset();
        idle();
        flush     = 1'b0;
        mem_ready = 1'b1;
        rst       = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        fwd_enable = 1'b0;
        flush      = 1'b0;
        mem_ready  = 1'b1;
        idle();
        step();
        chk(SIG_STALL, 0, "rst_stall");
        chk(SIG_FREEZE, 0, "rst_freeze");
        chk(SIG_FA, 0, "rst_fa");
        chk(SIG_FB, 0, "rst_fb");
        chk(SIG_CNT, 0, "rst_cnt");
        #1;
        checks++;
        if (hazard_stall !== 1'b0 || mem_freeze !== 1'b0) begin
            errors++;
            $display("FAIL rst_direct_ctrl");
        end
        checks++;
        if (stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_direct_cnt: got %0d", stall_count);
        end
        step();
        rst = 1'b1;

        // stall-only RAW on an EXE writer
        do_reset();
        fwd_enable = 1'b0;
        issue(4'd1, 4'd5, 4'd6, 1, 1, 0);
        chk(SIG_STALL, 0, "t1_first");
        step();
        issue(4'd7, 4'd1, 4'd6, 1, 1, 0);
        chk(SIG_STALL, 1, "t1_stall_c1");
        #1;
        checks++;
        if (hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL t1_direct_stall");
        end
        step();
        chk(SIG_STALL, 1, "t1_stall_c2");
        step();
        chk(SIG_STALL, 0, "t1_release");
        chk(SIG_CNT, 2, "t1_count");
        #1;
        checks++;
        if (stall_count !== 16'd2) begin
            errors++;
            $display("FAIL t1_direct_cnt: got %0d", stall_count);
        end
        step();
        idle();
        step();

        // forwarding from MEM and WB
        do_reset();
        fwd_enable = 1'b1;
        issue(4'd2, 4'd8, 4'd9, 1, 1, 0);
        step();
        issue(4'd10, 4'd2, 4'd3, 1, 1, 0);
        chk(SIG_STALL, 0, "t2_no_stall");
        step();
        idle();
        chk(SIG_FA, 1, "t2_fa_mem");
        chk(SIG_FB, 0, "t2_fb_none");
        #1;
        checks++;
        if (fwd_sel_a !== 2'd1) begin
            errors++;
            $display("FAIL t2_direct_fa: got %0d", fwd_sel_a);
        end
        step();
        issue(4'd2, 4'd8, 4'd9, 1, 1, 0);
        step();
        issue(4'd11, 4'd12, 4'd13, 1, 1, 0);
        step();
        issue(4'd10, 4'd2, 4'd3, 1, 1, 0);
        step();
        idle();
        chk(SIG_FA, 2, "t2_fa_wb");
        chk(SIG_FB, 0, "t2_fb_wb_none");
        chk(SIG_CNT, 0, "t2_count");
        step();

        // load-use
        do_reset();
        fwd_enable = 1'b1;
        issue(4'd3, 4'd4, 4'd0, 1, 0, 1);
        step();
        issue(4'd5, 4'd6, 4'd3, 1, 1, 0);
        chk(SIG_STALL, 1, "t3_load_use");
        step();
        chk(SIG_STALL, 0, "t3_one_cycle");
        step();
        idle();
        chk(SIG_FB, 2, "t3_fb_wb");
        chk(SIG_FA, 0, "t3_fa_none");
        chk(SIG_CNT, 1, "t3_count");
        #1;
        checks++;
        if (fwd_sel_b !== 2'd2) begin
            errors++;
            $display("FAIL t3_direct_fb: got %0d", fwd_sel_b);
        end
        step();

        // memory wait freeze
        do_reset();
        fwd_enable = 1'b1;
        issue(4'd4, 4'd8, 4'd9, 1, 1, 0);
        step();
        issue(4'd3, 4'd10, 4'd0, 1, 0, 1);
        step();
        issue(4'd5, 4'd4, 4'd11, 1, 1, 0);
        chk(SIG_STALL, 0, "t4_gap");
        step();
        issue(4'd6, 4'd12, 4'd13, 1, 1, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk(SIG_FREEZE, 1, "t4_freeze");
            chk(SIG_FA, 2, "t4_slots_held");
            chk(SIG_STALL, 0, "t4_no_stall");
            step();
        end
        mem_ready = 1'b1;
        chk(SIG_FREEZE, 0, "t4_release");
        chk(SIG_FA, 2, "t4_fa_after");
        chk(SIG_CNT, 4, "t4_count");
        #1;
        checks++;
        if (stall_count !== 16'd4) begin
            errors++;
            $display("FAIL t4_direct_cnt: got %0d", stall_count);
        end
        step();
        idle();
        chk(SIG_FA, 0, "t4_shifted");
        step();

        // flush beats a RAW stall and bubbles slot0
        do_reset();
        fwd_enable = 1'b0;
        issue(4'd1, 4'd5, 4'd6, 1, 1, 0);
        step();
        issue(4'd7, 4'd1, 4'd6, 1, 1, 0);
        flush = 1'b1;
        chk(SIG_STALL, 0, "t5_flush_stall");
        step();
        flush = 1'b0;
        issue(4'd8, 4'd7, 4'd0, 1, 0, 0);
        chk(SIG_STALL, 0, "t5_bubble");
        step();
        idle();
        step();

        // flush during freeze is held until memory is ready
        do_reset();
        fwd_enable = 1'b1;
        issue(4'd4, 4'd8, 4'd9, 1, 1, 0);
        step();
        issue(4'd3, 4'd10, 4'd0, 1, 0, 1);
        step();
        issue(4'd5, 4'd4, 4'd11, 1, 1, 0);
        step();
        issue(4'd6, 4'd5, 4'd0, 1, 0, 0);
        mem_ready = 1'b0;
        flush     = 1'b1;
        chk(SIG_FREEZE, 1, "t5_frz");
        chk(SIG_STALL, 0, "t5_frz_stall");
        chk(SIG_FA, 2, "t5_frz_held");
        step();
        mem_ready = 1'b1;
        chk(SIG_FREEZE, 0, "t5_frz_release");
        chk(SIG_FA, 2, "t5_flush_pending");
        step();
        flush = 1'b0;
        idle();
        chk(SIG_FA, 0, "t5_flush_applied");
        chk(SIG_CNT, 1, "t5_count");
        step();

        // counter saturation and reset mid-stall
        do_reset();
        fwd_enable = 1'b1;
        issue(4'd3, 4'd10, 4'd0, 1, 0, 1);
        step();
        idle();
        step();
        mem_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k >= 14) begin
                chk(SIG_CNT, k, "t6_count");
                chk(SIG_SMALL, (k > 15) ? 15 : k, "t6_saturate");
            end
            step();
        end
        #1;
        checks++;
        if (s_count !== 4'hF) begin
            errors++;
            $display("FAIL t6_direct_sat: got %0d", s_count);
        end
        rst = 1'b0;
        chk(SIG_STALL, 0, "t6_rst_stall");
        chk(SIG_FREEZE, 0, "t6_rst_freeze");
        chk(SIG_FA, 0, "t6_rst_fa");
        chk(SIG_FB, 0, "t6_rst_fb");
        chk(SIG_CNT, 0, "t6_rst_cnt");
        chk(SIG_SMALL, 0, "t6_rst_small");
        #1;
        checks++;
        if (stall_count !== 16'd0 || s_count !== 4'd0) begin
            errors++;
            $display("FAIL t6_direct_rst");
        end
        step();
        rst       = 1'b1;
        mem_ready = 1'b1;
        step();
        step();

        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never compared (cycle %0d)", e.name, e.cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
